// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: capture FSM states, default frame geometry and data-slice helper
package adc_capture_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_FALL, SHIFT, END_FALL, QUIET} state_e;
  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_LEAD_BITS = 3;
  localparam int DEF_DATA_BITS = 8;
  function automatic int data_lsb(input int frame_bits, input int lead_bits, input int data_bits);
    return frame_bits - lead_bits - data_bits;
  endfunction
endpackage

// File: rtl/adc_sclk_edge.sv
// adc_sclk_edge: sclk rise/fall pulse detect and 2-flop serial data sync (clk, rst, sclk_in, sdata_in -> rise, fall, sdata_sync)
module adc_sclk_edge (
  input  logic clk,
  input  logic rst,
  input  logic sclk_in,
  input  logic sdata_in,
  output logic rise,
  output logic fall,
  output logic sdata_sync
);
  logic sclk_q, meta_q, sync_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= 1'b0;
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sclk_q <= sclk_in;
      meta_q <= sdata_in;
      sync_q <= meta_q;
    end
  end
  assign rise = sclk_in & ~sclk_q;
  assign fall = ~sclk_in & sclk_q;
  assign sdata_sync = sync_q;
endmodule

// File: rtl/adc_serial_capture.sv
// adc_serial_capture: framed serial ADC read-out (Clck_in, reset_Clock, sclk_in, start, adc_sdata -> adc_cs_n, data_out, data_valid, frame_err, busy)
module adc_serial_capture
  import adc_capture_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int LEAD_BITS  = DEF_LEAD_BITS,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                 Clck_in,
  input  logic                 reset_Clock,
  input  logic                 sclk_in,
  input  logic                 start,
  input  logic                 adc_sdata,
  output logic                 adc_cs_n,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int LSB = data_lsb(FRAME_BITS, LEAD_BITS, DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);
  localparam logic [FRAME_BITS-1:0] DMASK = FRAME_BITS'({DATA_BITS{1'b1}}) << LSB;
  logic rise, fall, sd_sync;
  state_e state_q, state_d;
  logic cs_n_q, cs_n_d, valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  adc_sclk_edge u_edge (
    .clk       (Clck_in),
    .rst       (reset_Clock),
    .sclk_in   (sclk_in),
    .sdata_in  (adc_sdata),
    .rise      (rise),
    .fall      (fall),
    .sdata_sync(sd_sync)
  );
  always_comb begin
    state_d = state_q;
    cs_n_d  = cs_n_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = err_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:      if (start || CONTINUOUS) state_d = WAIT_FALL;
      WAIT_FALL: if (fall) begin
        cs_n_d  = 1'b0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT:     if (rise) begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], sd_sync};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? END_FALL : SHIFT;
      end
      END_FALL:  if (fall) begin
        cs_n_d  = 1'b1;
        data_d  = shreg_q[LSB +: DATA_BITS];
        valid_d = 1'b1;
        err_d   = |(shreg_q & ~DMASK);
        state_d = QUIET;
      end
      QUIET:     if (rise) state_d = CONTINUOUS ? WAIT_FALL : IDLE;
      default:   state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge Clck_in) begin
    if (reset_Clock) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end
  assign adc_cs_n   = cs_n_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_adc_serial_capture.sv
// tb_adc_serial_capture: vector table, hand sequences and random frames against an ADC word model
module tb_adc_serial_capture;
  localparam int HALF = 8;
  localparam int P = 2 * HALF;
  logic clk = 1'b0;
  logic rst_a, rst_c, sclk, start_a, start_c, sd_a, sd_c;
  logic cs_a, valid_a, err_a, busy_a, cs_c, valid_c, err_c, busy_c;
  logic [7:0] data_a, data_c;
  logic [15:0] word_a, word_c;
  logic [15:0] q_c[$];
  int idx_a, idx_c;
  int vectors = 0, miscompares = 0;
  typedef struct {
    logic [15:0] word;
    logic [7:0]  exp_d;
    logic        exp_e;
  } vec_t;
  vec_t tbl[9];

  adc_serial_capture #(.CONTINUOUS(1'b0)) dut (
    .Clck_in(clk), .reset_Clock(rst_a), .sclk_in(sclk), .start(start_a), .adc_sdata(sd_a),
    .adc_cs_n(cs_a), .data_out(data_a), .data_valid(valid_a), .frame_err(err_a), .busy(busy_a));
  adc_serial_capture #(.CONTINUOUS(1'b1)) dut_c (
    .Clck_in(clk), .reset_Clock(rst_c), .sclk_in(sclk), .start(start_c), .adc_sdata(sd_c),
    .adc_cs_n(cs_c), .data_out(data_c), .data_valid(valid_c), .frame_err(err_c), .busy(busy_c));

  initial forever #5 clk = ~clk;

  // divided clock plus an ADC that presents the MSB when CS drops and shifts on each sclk fall
  initial begin
    logic fell, prev_a, prev_c;
    int hcnt;
    sclk = 1'b0; sd_a = 1'b0; sd_c = 1'b0; hcnt = 0; prev_a = 1'b1; prev_c = 1'b1;
    idx_a = 0; idx_c = 0; word_c = '0;
    forever begin
      @(negedge clk);
      fell = 1'b0;
      if (hcnt == HALF - 1) begin
        hcnt = 0;
        sclk = ~sclk;
        fell = !sclk;
      end else hcnt++;
      if (cs_a === 1'b0 && prev_a === 1'b1) begin
        idx_a = 15; sd_a = word_a[15];
      end else if (cs_a === 1'b0 && fell && idx_a > 0) begin
        idx_a--; sd_a = word_a[idx_a];
      end else if (cs_a === 1'b1) sd_a = 1'($urandom_range(0, 1));
      if (cs_c === 1'b0 && prev_c === 1'b1) begin
        word_c = (q_c.size() > 0) ? q_c.pop_front() : 16'h0000;
        idx_c = 15; sd_c = word_c[15];
      end else if (cs_c === 1'b0 && fell && idx_c > 0) begin
        idx_c--; sd_c = word_c[idx_c];
      end else if (cs_c === 1'b1) sd_c = 1'($urandom_range(0, 1));
      prev_a = cs_a;
      prev_c = cs_c;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame_a(input logic [15:0] w, input bit mid_start,
                             output logic [7:0] d, output logic e, output int nv, output int low);
    int t;
    word_a = w; nv = 0; low = 0; d = '0; e = 1'b0; t = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("busy_rise", busy_a, 1);
    while (busy_a === 1'b1 && t < 4000) begin
      if (cs_a === 1'b0) low++;
      if (valid_a === 1'b1) begin nv++; d = data_a; e = err_a; end
      if (mid_start && t == 200) start_a = 1'b1;
      if (mid_start && t == 201) start_a = 1'b0;
      @(negedge clk);
      t++;
    end
    check("frame_timeout", t < 4000, 1);
  endtask

  task automatic quiet_watch(input int cycles, output int nv, output int low);
    nv = 0; low = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (valid_a !== 1'b0) nv++;
      if (cs_a !== 1'b1 || busy_a !== 1'b0) low++;
    end
  endtask

  task automatic frame_and_check(input string tag, input logic [15:0] w, input logic [7:0] ed, input logic ee);
    logic [7:0] d; logic e; int nv, low;
    run_frame_a(w, 1'b0, d, e, nv, low);
    check({tag, "_data"}, d, ed);
    check({tag, "_err"}, e, ee);
    check({tag, "_nvalid"}, nv, 1);
    check({tag, "_cs_low"}, low, 16 * P);
    repeat (5) @(negedge clk);
    check({tag, "_hold"}, data_a, ed);
  endtask

  initial begin
    int nv, low, t, gaps, gap, min_gap, hi_start;
    logic prev;
    logic [7:0] got[3];
    logic [7:0] d; logic e;
    logic [15:0] w;
    tbl[0] = '{16'h14A0, 8'hA5, 1'b0};
    tbl[1] = '{16'h41E1, 8'h0F, 1'b1};
    tbl[2] = '{16'h0000, 8'h00, 1'b0};
    tbl[3] = '{16'hFFFF, 8'hFF, 1'b1};
    tbl[4] = '{16'h1FE0, 8'hFF, 1'b0};
    tbl[5] = '{16'h8000, 8'h00, 1'b1};
    tbl[6] = '{16'h0001, 8'h00, 1'b1};
    tbl[7] = '{16'h0020, 8'h01, 1'b0};
    tbl[8] = '{16'h1000, 8'h80, 1'b0};
    rst_a = 1'b1; rst_c = 1'b1; start_a = 1'b0; start_c = 1'b0; word_a = '0;
    repeat (4) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check("rst_cs_n", cs_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_err", err_a, 0);
    quiet_watch(5 * P, nv, low);
    check("idle_valid", nv, 0);
    check("idle_active", low, 0);
    for (int i = 0; i < 9; i++) frame_and_check($sformatf("tbl%0d", i), tbl[i].word, tbl[i].exp_d, tbl[i].exp_e);
    // reset after seven bits of a frame
    word_a = 16'h41E1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    t = 0;
    while (cs_a !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    check("midrst_cs_fall", t < 200, 1);
    repeat (7 * P) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("midrst_cs_n", cs_a, 1);
    check("midrst_busy", busy_a, 0);
    check("midrst_data", data_a, 0);
    check("midrst_valid", valid_a, 0);
    quiet_watch(3 * P, nv, low);
    check("midrst_no_valid", nv, 0);
    check("midrst_stays_idle", low, 0);
    frame_and_check("after_rst", 16'h14A0, 8'hA5, 1'b0);
    // second start mid-SHIFT must not queue another frame
    run_frame_a(16'h14A0, 1'b1, d, e, nv, low);
    check("busy_start_data", d, 8'hA5);
    check("busy_start_nvalid", nv, 1);
    check("busy_start_cs_low", low, 16 * P);
    quiet_watch(4 * P, nv, low);
    check("busy_start_no_extra", low, 0);
    for (int i = 0; i < 12; i++) begin
      w = 16'($urandom);
      frame_and_check($sformatf("rnd%0d", i), w, 8'((w >> 5) & 16'h00FF), (w & 16'hE01F) != 16'h0);
    end
    // continuous mode instance
    q_c = {16'h0000, 16'h1FE0, 16'h0780};
    @(negedge clk); rst_c = 1'b0;
    nv = 0; gaps = 0; min_gap = 1 << 30; hi_start = 0; prev = 1'b1; t = 0;
    got[0] = 'x; got[1] = 'x; got[2] = 'x;
    while (nv < 3 && t < 3000) begin
      @(negedge clk);
      t++;
      if (valid_c === 1'b1) begin got[nv] = data_c; nv++; end
      if (cs_c === 1'b1 && prev === 1'b0) hi_start = t;
      if (cs_c === 1'b0 && prev === 1'b1 && nv > 0) begin
        gaps++;
        gap = t - hi_start;
        if (gap < min_gap) min_gap = gap;
      end
      prev = cs_c;
    end
    check("cont_count", nv, 3);
    check("cont_v0", got[0], 8'h00);
    check("cont_v1", got[1], 8'hFF);
    check("cont_v2", got[2], 8'h3C);
    check("cont_gaps", gaps, 2);
    check("cont_min_gap_ok", min_gap >= P, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
